modn_timer: RTL

//  Second-generation modulo-N timer for the timer0 subsystem. Counts up or down modulo a

---
 rtl/modn_timer.sv | 107 ++++++++++
 1 files changed

// File: rtl/modn_timer.sv
// Modulo-N up/down timer with programmable prescaler and a periodic or one-shot mode.
// Emits a registered one-cycle terminal-count pulse and a busy flag while running.
module modn_timer #(
  parameter int N         = 8,
  parameter int M_DEFAULT = 10,
  parameter int PRE_W     = 4
) (
  input  logic             clk_50,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             start,
  input  logic             load,
  input  logic [N-1:0]     mod_in,
  input  logic [PRE_W-1:0] pre_div,
  output logic [N-1:0]     cnt_num,
  output logic             tc,
  output logic             busy
);

  generate
    if (M_DEFAULT < 1 || M_DEFAULT > (2 ** N) - 1) begin : g_bad_mod
      $error("modn_timer: M_DEFAULT out of range 1..2^N-1");
    end
  endgenerate

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic [N-1:0]     mod_q, mod_nxt;
  logic [N-1:0]     cnt_nxt;
  logic [PRE_W-1:0] pre_cnt, pre_nxt;
  logic             tc_nxt;

  // Value the count restarts from for a given direction and modulus.
  function automatic logic [N-1:0] start_val(input logic d, input logic [N-1:0] m);
    return d ? m - N'(1) : '0;
  endfunction

  // Value at which the next tick is terminal.
  function automatic logic [N-1:0] term_val(input logic d, input logic [N-1:0] m);
    return d ? '0 : m - N'(1);
  endfunction

  always_ff @(posedge clk_50) begin
    if (rst) begin
      state   <= IDLE;
      mod_q   <= N'(M_DEFAULT);
      cnt_num <= '0;
      pre_cnt <= '0;
      tc      <= 1'b0;
    end else begin
      state   <= state_nxt;
      mod_q   <= mod_nxt;
      cnt_num <= cnt_nxt;
      pre_cnt <= pre_nxt;
      tc      <= tc_nxt;
    end
  end

  // A valid load pre-empts both the state transition and any same-edge tick.
  always_comb begin
    state_nxt = state;
    mod_nxt   = mod_q;
    cnt_nxt   = cnt_num;
    pre_nxt   = pre_cnt;
    tc_nxt    = 1'b0;
    if (load && (mod_in != '0)) begin
      mod_nxt = mod_in;
      cnt_nxt = start_val(dir, mod_in);
      pre_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (en && (!mode || start)) begin
            state_nxt = RUN;
            cnt_nxt   = start_val(dir, mod_q);
            pre_nxt   = '0;
          end
        end
        RUN: begin
          if (en) begin
            if (pre_cnt == pre_div) begin
              pre_nxt = '0;
              if (cnt_num == term_val(dir, mod_q)) begin
                cnt_nxt = start_val(dir, mod_q);
                tc_nxt  = 1'b1;
                if (mode) state_nxt = IDLE;
              end else if (dir) begin
                cnt_nxt = cnt_num - N'(1);
              end else begin
                cnt_nxt = cnt_num + N'(1);
              end
            end else begin
              pre_nxt = pre_cnt + PRE_W'(1);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);

endmodule
